// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Purpose : bundles the pipeline request/response handshake and the data
//           memory port of the load/store unit into one interface.
// Signals :
//   req_valid/req_ready       request handshake (pipeline -> LSU)
//   req_write/req_size/req_signed/req_addr/req_wdata   request payload
//   resp_valid/resp_rdata/resp_err                     one-cycle completion
//   mem_addr/mem_read/mem_write/mem_wdata/mem_rdata    word-wide data memory
// Modports: slave  = the LSU itself
//           master = the pipeline + memory side (testbench)
// ----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [17:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Purpose : single-outstanding load/store unit in front of a word-wide data
//           memory. Byte/halfword/word accesses, little-endian lanes, sign or
//           zero extension on loads, read-modify-write for sub-word stores.
// Ports   :
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset (also gates memory strobes)
//   bus    slave modport of load_store_unit_if (request, response, memory)
// ----------------------------------------------------------------------------
module load_store_unit (
    input  logic                 clk,
    input  logic                 rst_n,
    load_store_unit_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [17:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_accept;
    logic        w_err;

    // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the target lane(s) of the old word; every other bit is kept.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'h00_0000, wdata[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {lane, 3'b000};
                data = {16'h0000, wdata[15:0]} << {lane, 3'b000};
            end
            2'b10: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
            default: begin
                mask = 32'h0000_0000;
                data = 32'h0000_0000;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    assign w_accept = bus.req_valid & r_ready;

    // Request legality: illegal size, misalignment, or address beyond 1 MiB.
    always_comb begin
        w_err = 1'b0;
        case (bus.req_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = bus.req_addr[0];
            2'b10:   w_err = (bus.req_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
        if (bus.req_addr[31:20] != 12'h000) begin
            w_err = 1'b1;
        end else begin
            w_err = w_err;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_wdata      <= 32'h0000_0000;
            r_ready      <= 1'b1;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 18'h0_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write    <= bus.req_write;
                        r_signed   <= bus.req_signed;
                        r_size     <= bus.req_size;
                        r_lane     <= bus.req_addr[1:0];
                        r_wdata    <= bus.req_wdata;
                        r_mem_addr <= bus.req_addr[19:2];
                        r_ready    <= 1'b0;
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                            r_state      <= RESP;
                        end else if (bus.req_write && (bus.req_size == 2'b10)) begin
                            // Full-word store needs no read of the old contents.
                            r_mem_wdata <= bus.req_wdata;
                            r_mem_write <= 1'b1;
                            r_state     <= WRITE;
                        end else begin
                            // Loads, and sub-word stores that need the old word.
                            r_mem_read <= 1'b1;
                            r_state    <= READ;
                        end
                    end
                end
                READ: begin
                    r_mem_read <= 1'b0;
                    if (r_write) begin
                        r_mem_wdata <= store_merge(bus.mem_rdata, r_wdata, r_size, r_lane);
                        r_mem_write <= 1'b1;
                        r_state     <= WRITE;
                    end else begin
                        r_resp_rdata <= load_extract(bus.mem_rdata, r_size, r_lane, r_signed);
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by rst_n so a reset mid-access never touches memory.
    assign bus.mem_read   = r_mem_read  & rst_n;
    assign bus.mem_write  = r_mem_write & rst_n;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

endmodule
